// File: rtl/pat_pkg.sv
// Shared types and constants for the program-counter sequencer and its call stack.
package pat_pkg;

    localparam int I_ADR_WIDTH_DEF     = 10;
    localparam int CALL_STACK_SIZE_DEF = 8;
    localparam int CSP_WIDTH_DEF       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } pc_state_e;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO: push writes at the current depth, dout always shows the top entry.
module call_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   depth,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   depth_r;
    logic [PTR_W:0]   top_s;
    logic             full_s;

    assign full_s = (depth_r == (PTR_W+1)'(DEPTH));
    assign top_s  = depth_r - {{PTR_W{1'b0}}, 1'b1};

    // Occupancy counter; clear wins over push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_r <= '0;
        end else if (clr) begin
            depth_r <= '0;
        end else if (push && !full_s) begin
            depth_r <= depth_r + {{PTR_W{1'b0}}, 1'b1};
        end else if (pop && (depth_r != '0)) begin
            depth_r <= top_s;
        end else begin
            depth_r <= depth_r;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && !full_s && !clr) begin
            mem_r[depth_r[PTR_W-1:0]] <= din;
        end
    end

    assign dout  = mem_r[top_s[PTR_W-1:0]];
    assign depth = depth_r;
    assign full  = full_s;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branches and an optional call/return stack.
// Define PAT_CALL_STACK_EN to build the return-address stack; otherwise calls act as forward branches.
module pc_sequencer
    import pat_pkg::*;
#(
    parameter int I_ADR_WIDTH     = I_ADR_WIDTH_DEF,
    parameter int CALL_STACK_SIZE = CALL_STACK_SIZE_DEF,
    parameter int CSP_WIDTH       = CSP_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   advance,
    input  logic                   op_bf,
    input  logic                   op_bb,
    input  logic                   op_call,
    input  logic                   op_ret,
    input  logic                   cond_true,
    input  logic [7:0]             offset,
    input  logic                   err_clr,
    output logic [I_ADR_WIDTH-1:0] pc,
    output logic                   fetch_valid,
    output logic [CSP_WIDTH:0]     depth,
    output logic                   stack_full,
    output logic [1:0]             err_code
);

    pc_state_e              state_r;
    logic [I_ADR_WIDTH-1:0] pc_r;
    logic [1:0]             err_r;
    logic                   fetch_valid_r;

    logic [I_ADR_WIDTH-1:0] pc_inc_s;
    logic [I_ADR_WIDTH-1:0] off_ext_s;
    logic [I_ADR_WIDTH-1:0] pc_next_s;
    logic                   run_adv_s;
    logic                   ovf_s;
    logic                   unf_s;
    logic                   clr_s;
    logic [CSP_WIDTH:0]     depth_s;
    logic                   stack_full_s;

    assign pc_inc_s  = pc_r + {{(I_ADR_WIDTH-1){1'b0}}, 1'b1};
    assign off_ext_s = I_ADR_WIDTH'(offset);
    assign run_adv_s = (state_r == ST_RUN) && advance;
    assign clr_s     = (state_r == ST_FAULT) && err_clr;

`ifdef PAT_CALL_STACK_EN
    logic                   push_s;
    logic                   pop_s;
    logic [I_ADR_WIDTH-1:0] top_s;

    call_stack #(
        .WIDTH (I_ADR_WIDTH),
        .DEPTH (CALL_STACK_SIZE),
        .PTR_W (CSP_WIDTH)
    ) u_call_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_s),
        .push    (push_s),
        .pop     (pop_s),
        .din     (pc_inc_s),
        .dout    (top_s),
        .depth   (depth_s),
        .full    (stack_full_s)
    );

    // Next-pc selection by op priority, with stack push/pop and fault detection.
    always_comb begin
        pc_next_s = pc_inc_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_s     = 1'b0;
        unf_s     = 1'b0;
        if (op_call && cond_true) begin
            if (stack_full_s) begin
                pc_next_s = pc_r;
                ovf_s     = run_adv_s;
            end else begin
                pc_next_s = pc_r + off_ext_s;
                push_s    = run_adv_s;
            end
        end else if (op_ret && cond_true) begin
            if (depth_s == '0) begin
                pc_next_s = pc_r;
                unf_s     = run_adv_s;
            end else begin
                pc_next_s = top_s;
                pop_s     = run_adv_s;
            end
        end else if (op_bf && cond_true) begin
            pc_next_s = pc_r + off_ext_s;
        end else if (op_bb && cond_true) begin
            pc_next_s = pc_r - off_ext_s;
        end else begin
            pc_next_s = pc_inc_s;
        end
    end
`else
    assign depth_s      = '0;
    assign stack_full_s = 1'b0;

    // Next-pc selection by op priority; without a stack a call is a forward branch.
    always_comb begin
        pc_next_s = pc_inc_s;
        ovf_s     = 1'b0;
        unf_s     = 1'b0;
        if (op_call && cond_true) begin
            pc_next_s = pc_r + off_ext_s;
        end else if (op_ret && cond_true) begin
            pc_next_s = pc_inc_s;
        end else if (op_bf && cond_true) begin
            pc_next_s = pc_r + off_ext_s;
        end else if (op_bb && cond_true) begin
            pc_next_s = pc_r - off_ext_s;
        end else begin
            pc_next_s = pc_inc_s;
        end
    end
`endif

    // Control FSM with registered pc, error code and fetch-valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= '0;
            err_r         <= ERR_NONE;
            fetch_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r       <= ST_RUN;
                    fetch_valid_r <= 1'b1;
                end
                ST_RUN: begin
                    if (ovf_s) begin
                        err_r         <= ERR_OVERFLOW;
                        state_r       <= ST_FAULT;
                        fetch_valid_r <= 1'b0;
                    end else if (unf_s) begin
                        err_r         <= ERR_UNDERFLOW;
                        state_r       <= ST_FAULT;
                        fetch_valid_r <= 1'b0;
                    end else if (run_adv_s) begin
                        pc_r <= pc_next_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_FAULT: begin
                    if (clr_s) begin
                        pc_r    <= '0;
                        err_r   <= ERR_NONE;
                        state_r <= ST_IDLE;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    pc_r          <= '0;
                    err_r         <= ERR_NONE;
                    fetch_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_r;
    assign fetch_valid = fetch_valid_r;
    assign depth       = depth_s;
    assign stack_full  = stack_full_s;
    assign err_code    = err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized ops against a queue-based model.
module tb_pc_sequencer;

    localparam int M  = 1024;
    localparam int SZ = 8;
`ifdef PAT_CALL_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       advance = 1'b0;
    logic       op_bf = 1'b0, op_bb = 1'b0, op_call = 1'b0, op_ret = 1'b0;
    logic       cond_true = 1'b0;
    logic [7:0] offset = 8'd0;
    logic       err_clr = 1'b0;
    logic [9:0] pc;
    logic       fetch_valid;
    logic [3:0] depth;
    logic       stack_full;
    logic [1:0] err_code;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model: state 0 idle, 1 run, 2 fault
    int m_pc;
    int m_state;
    int m_err;
    int m_stk[$];

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .advance(advance),
        .op_bf(op_bf), .op_bb(op_bb), .op_call(op_call), .op_ret(op_ret),
        .cond_true(cond_true), .offset(offset), .err_clr(err_clr),
        .pc(pc), .fetch_valid(fetch_valid), .depth(depth),
        .stack_full(stack_full), .err_code(err_code)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc = 0; m_state = 0; m_err = 0; m_stk.delete();
    endfunction

    function automatic void model_step(bit adv, bit call, bit ret, bit bf, bit bb, bit cond, int off, bit clr);
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 2) begin
            if (clr) begin
                m_pc = 0; m_err = 0; m_stk.delete(); m_state = 0;
            end
        end else if (adv) begin
            if (call && cond) begin
                if (!STACK_EN) m_pc = (m_pc + off) % M;
                else if (m_stk.size() == SZ) begin m_err = 1; m_state = 2; end
                else begin m_stk.push_back((m_pc + 1) % M); m_pc = (m_pc + off) % M; end
            end else if (ret && cond) begin
                if (!STACK_EN) m_pc = (m_pc + 1) % M;
                else if (m_stk.size() == 0) begin m_err = 2; m_state = 2; end
                else m_pc = m_stk.pop_back();
            end else if (bf && cond) m_pc = (m_pc + off) % M;
            else if (bb && cond) m_pc = (m_pc - off + M) % M;
            else m_pc = (m_pc + 1) % M;
        end
    endfunction

    task automatic step(input bit adv, input bit call, input bit ret, input bit bf,
                        input bit bb, input bit cond, input int off, input bit clr);
        advance = adv; op_call = call; op_ret = ret; op_bf = bf; op_bb = bb;
        cond_true = cond; offset = 8'(off); err_clr = clr;
        @(posedge clk);
        model_step(adv, call, ret, bf, bb, cond, off, clr);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (!(m_state == 1 && m_pc == target) && n < 2000) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            n++;
        end
        tests_run++;
        if (pc !== 10'(target) || n >= 2000) begin
            tests_failed++;
            $display("FAIL run_to pc=%0d expected %0d after %0d cycles", pc, target, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (pc !== 10'd0 || fetch_valid !== 1'b0 || depth !== 4'd0 || stack_full !== 1'b0 || err_code !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_state pc=%0d fv=%b depth=%0d full=%b err=%b expected all zero",
                     pc, fetch_valid, depth, stack_full, err_code);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        tests_run++;
        if (fetch_valid !== 1'b1 || pc !== 10'd0) begin
            tests_failed++;
            $display("FAIL first_run fv=%b pc=%0d expected fv=1 pc=0", fetch_valid, pc);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            tests_run++;
            if (pc !== 10'(i)) begin
                tests_failed++;
                $display("FAIL seq_pc pc=%0d expected %0d", pc, i);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_to(10);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0);
        tests_run++;
        if (pc !== 10'd15) begin
            tests_failed++; $display("FAIL bf_fwd pc=%0d expected 15", pc);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9, 1'b0);
        tests_run++;
        if (pc !== 10'd16) begin
            tests_failed++; $display("FAIL bf_not_taken pc=%0d expected 16", pc);
        end
        do_reset();
        run_to(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        tests_run++;
        if (pc !== 10'd1022) begin
            tests_failed++; $display("FAIL bb_wrap pc=%0d expected 1022", pc);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        tests_run++;
        if (pc !== 10'd1022) begin
            tests_failed++; $display("FAIL zero_offset_loop pc=%0d expected 1022", pc);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0);
        tests_run++;
        if (pc !== 10'd3) begin
            tests_failed++; $display("FAIL bf_wrap pc=%0d expected 3", pc);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
`ifdef PAT_CALL_STACK_EN
        run_to(20);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        tests_run++;
        if (pc !== 10'd28 || depth !== 4'd1) begin
            tests_failed++; $display("FAIL call pc=%0d depth=%0d expected 28/1", pc, depth);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        tests_run++;
        if (pc !== 10'd28 || depth !== 4'd1) begin
            tests_failed++; $display("FAIL hold pc=%0d depth=%0d expected 28/1", pc, depth);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0);
        tests_run++;
        if (pc !== 10'd21 || depth !== 4'd0) begin
            tests_failed++; $display("FAIL ret pc=%0d depth=%0d expected 21/0", pc, depth);
        end
`else
        run_to(2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        tests_run++;
        if (pc !== 10'd6 || depth !== 4'd0) begin
            tests_failed++; $display("FAIL call_as_bf pc=%0d depth=%0d expected 6/0", pc, depth);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9, 1'b0);
        tests_run++;
        if (pc !== 10'd7 || depth !== 4'd0 || err_code !== 2'b00) begin
            tests_failed++; $display("FAIL ret_as_seq pc=%0d depth=%0d err=%b expected 7/0/00", pc, depth, err_code);
        end
`endif
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1);
        tests_run++;
        if (pc !== 10'(m_pc) || depth !== 4'd0 || fetch_valid !== 1'b1) begin
            tests_failed++; $display("FAIL call_not_taken pc=%0d depth=%0d expected %0d/0", pc, depth, m_pc);
        end
    endtask

    task automatic test_overflow();
        int frozen;
        do_reset();
        run_to(0);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        tests_run++;
        if (depth !== 4'(STACK_EN ? 8 : 0) || stack_full !== STACK_EN || pc !== 10'd8) begin
            tests_failed++; $display("FAIL eight_calls depth=%0d full=%b pc=%0d", depth, stack_full, pc);
        end
        frozen = 8;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
`ifdef PAT_CALL_STACK_EN
        tests_run++;
        if (err_code !== 2'b01 || pc !== 10'(frozen) || fetch_valid !== 1'b0 || depth !== 4'd8) begin
            tests_failed++; $display("FAIL overflow err=%b pc=%0d fv=%b depth=%0d expected 01/%0d/0/8",
                                     err_code, pc, fetch_valid, depth, frozen);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7, 1'b0);
        tests_run++;
        if (err_code !== 2'b01 || pc !== 10'(frozen)) begin
            tests_failed++; $display("FAIL fault_hold err=%b pc=%0d", err_code, pc);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        tests_run++;
        if (pc !== 10'd0 || depth !== 4'd0 || err_code !== 2'b00 || fetch_valid !== 1'b0 || stack_full !== 1'b0) begin
            tests_failed++; $display("FAIL err_clr pc=%0d depth=%0d err=%b fv=%b", pc, depth, err_code, fetch_valid);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        tests_run++;
        if (fetch_valid !== 1'b1 || pc !== 10'd0) begin
            tests_failed++; $display("FAIL rerun fv=%b pc=%0d expected 1/0", fetch_valid, pc);
        end
`else
        tests_run++;
        if (err_code !== 2'b00 || pc !== 10'(frozen + 1) || fetch_valid !== 1'b1) begin
            tests_failed++; $display("FAIL no_overflow err=%b pc=%0d fv=%b", err_code, pc, fetch_valid);
        end
`endif
    endtask

    task automatic test_underflow();
        do_reset();
        run_to(5);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        tests_run++;
        if (err_code !== 2'(STACK_EN ? 2 : 0) || pc !== 10'(STACK_EN ? 5 : 6) || fetch_valid !== !STACK_EN) begin
            tests_failed++; $display("FAIL ret_empty err=%b pc=%0d fv=%b", err_code, pc, fetch_valid);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        tests_run++;
        if (pc !== 10'(m_pc) || err_code !== 2'(m_err) || fetch_valid !== (m_state == 1)) begin
            tests_failed++; $display("FAIL clr_after_ret pc=%0d err=%b expected %0d/%0d", pc, err_code, m_pc, m_err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_to(4);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (pc !== 10'd0 || depth !== 4'd0 || fetch_valid !== 1'b0 || err_code !== 2'b00 || stack_full !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset pc=%0d depth=%0d fv=%b", pc, depth, fetch_valid);
        end
        do_reset();
    endtask

    task automatic test_random();
        bit a, c, r, f, b, cd, cl;
        int off;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 3) == 0);
            cd = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 4) == 0);
            off = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            step(a, c, r, f, b, cd, off, cl);
            tests_run++;
            if (pc !== 10'(m_pc) || fetch_valid !== (m_state == 1) || depth !== 4'(m_stk.size()) ||
                stack_full !== (m_stk.size() == SZ) || err_code !== 2'(m_err)) begin
                tests_failed++;
                $display("FAIL random[%0d] pc=%0d fv=%b depth=%0d full=%b err=%b expected pc=%0d st=%0d depth=%0d err=%0d",
                         i, pc, fetch_valid, depth, stack_full, err_code, m_pc, m_state, m_stk.size(), m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter I_ADR_WIDTH, default 10, program counter width.
REQ-002 Parameter CALL_STACK_SIZE, default 8, return-address LIFO depth.
REQ-003 Parameter CSP_WIDTH, default 3, call stack pointer bits; depth output is CSP_WIDTH+1 bits.
REQ-004 The interface SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port advance, input, 1, current instruction retires this cycle.
REQ-008 Ports op_bf, op_bb, op_call, op_ret, input, 1 each, decoded control ops.
REQ-009 Port cond_true, input, 1, branch/call/ret condition satisfied.
REQ-010 Port offset, input, 8, unsigned branch offset.
REQ-011 Port err_clr, input, 1, leave FAULT.
REQ-012 Port pc, output, I_ADR_WIDTH, registered fetch address.
REQ-013 Port fetch_valid, output, 1, pc is valid for fetch.
REQ-014 Port depth, output, CSP_WIDTH+1, stack occupancy 0..CALL_STACK_SIZE.
REQ-015 Port stack_full, output, 1, depth == CALL_STACK_SIZE.
REQ-016 Port err_code, output, 2, 00 none, 01 overflow, 10 underflow; held until err_clr.

Function
REQ-017 The block SHALL implement states IDLE, RUN, FAULT; IDLE always goes to RUN after one cycle.
REQ-018 fetch_valid SHALL be 1 only in RUN.
REQ-019 In RUN with advance=0, pc, depth and stack contents SHALL hold.
REQ-020 In RUN with advance=1, op priority SHALL be op_call > op_ret > op_bf > op_bb > sequential.
REQ-021 A control op with cond_true=0, or no op, SHALL set pc <= pc+1.
REQ-022 Taken op_bf SHALL set pc <= pc + zero-extended offset, modulo 2^I_ADR_WIDTH.
REQ-023 Taken op_bb SHALL set pc <= pc - zero-extended offset, modulo 2^I_ADR_WIDTH.
REQ-024 Offset 0 on a taken op_bf or op_bb SHALL leave pc unchanged, giving a one-instruction loop.
REQ-025 Taken op_call with depth < CALL_STACK_SIZE SHALL push pc+1, increment depth, and set pc <= pc+offset.
REQ-026 Taken op_ret with depth > 0 SHALL set pc <= top entry and decrement depth.
REQ-027 Taken op_call with stack_full=1 SHALL leave pc and stack unchanged, set err_code=01, and enter FAULT.
REQ-028 Taken op_ret with depth=0 SHALL leave pc unchanged, set err_code=10, and enter FAULT.
REQ-029 In FAULT, pc, depth and err_code SHALL hold regardless of advance.
REQ-030 err_clr in FAULT SHALL clear pc, depth and err_code to 0 and go to IDLE; err_clr outside FAULT SHALL be ignored.
REQ-031 Every update SHALL take effect on the clk edge and be visible on pc in the next cycle (one-cycle latency).

Reset
REQ-032 While reset_n=0, state SHALL be IDLE, pc=0, depth=0, err_code=00, fetch_valid=0, and stack_full=0, including when reset_n falls mid-operation.
REQ-033 Stack storage contents need not be reset.

Configuration
REQ-034 With macro PAT_CALL_STACK_EN defined, REQ-025 through REQ-028 SHALL apply.
REQ-035 Without PAT_CALL_STACK_EN, there SHALL be no stack storage: taken op_call acts as op_bf, op_ret acts as sequential, depth=0, stack_full=0, and FAULT is unreachable.

Structure
REQ-036 Package pat_pkg SHALL hold the state enum, the err_code constants, and the default width constants.
REQ-037 The return-address LIFO SHALL be sub-module call_stack, with push/pop, data in/out, depth and full.

Verification
REQ-038 Release reset, advance=1, no ops -> pc 0,1,2,3; fetch_valid rises one cycle after reset release.
REQ-039 pc=10, taken op_bf offset 5 -> pc=15; pc=3, taken op_bb offset 5 -> pc=1022 (wrap).
REQ-040 pc=20, taken op_call offset 8 -> pc=28, depth=1; taken op_ret -> pc=21, depth=0.
REQ-041 Nine taken op_calls -> depth=8, stack_full=1 after the eighth; the ninth sets err_code=01 with pc frozen; err_clr -> pc=0, IDLE, then RUN.
REQ-042 op_ret at depth 0 -> err_code=10, FAULT; op_call with cond_true=0 -> pc+1, depth unchanged.
REQ-043 reset_n pulsed low mid-call-sequence -> pc=0, depth=0 asynchronously; without PAT_CALL_STACK_EN, op_call offset 4 at pc=2 -> pc=6, depth=0.
